mem_access: RTL and testbench

Memory-access stage controller for the 5-stage MIPS pipeline. It sits between the EX/MEM register and the MEM/WB register. It turns the M-stage load/store into a request/acknowledge transaction on the data-memory bus, aligns store data and byte strobes, and extracts and sign- or zero-extends load data into `readdataM`. It also flags misaligned-address exceptions and stalls the pipeline until the transaction completes.

---
 rtl/mem_access_if.sv | 22 ++
 rtl/mem_access.sv | 166 ++++++++++++++++
 tb/tb_mem_access.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Data-memory request/acknowledge bus between the MEM stage and the memory system.
interface mem_access_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok;
    logic [31:0] data_rdata;
    logic        data_data_ok;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
        input  data_addr_ok, data_rdata, data_data_ok
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
        output data_addr_ok, data_rdata, data_data_ok
    );
endinterface

// File: rtl/mem_access.sv
// MEM-stage controller: turns M-stage loads/stores into one bus transaction at a time,
// formats store data/strobes, extracts load data and stalls the pipeline until done.
module mem_access (
    input  logic               clk,
    input  logic               rst,
    input  logic               memenM,
    input  logic               memwriteM,
    input  logic [2:0]         memopM,
    input  logic [31:0]        aluoutM,
    input  logic [31:0]        writedataM,
    input  logic               flushM,
    input  logic               advanceM,
    output logic [31:0]        readdataM,
    output logic               stallM,
    output logic               adelM,
    output logic               adesM,
    mem_access_if.master       bus
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic        discard_q, discard_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wd_q, wd_d;
    logic [2:0]  op_q, op_d;
    logic        wr_q, wr_d;

    logic        mis;
    logic        start;
    logic        use_q;
    logic [31:0] req_addr;
    logic [31:0] req_wd;
    logic [2:0]  req_op;
    logic        req_wr;
    logic [31:0] load_data;

    function automatic logic [31:0] fmt_load(input logic [2:0] op, input logic [1:0] a,
                                             input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{a, 3'b000} +: 8];
        h = a[1] ? rd[31:16] : rd[15:0];
        if (op[2])
            return rd;
        else if (op[1])
            return op[0] ? {16'h0000, h} : {{16{h[15]}}, h};
        else
            return op[0] ? {24'h000000, b} : {{24{b[7]}}, b};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            discard_q <= 1'b0;
            hold_q    <= 32'h0;
            addr_q    <= 32'h0;
            wd_q      <= 32'h0;
            op_q      <= 3'b000;
            wr_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            hold_q    <= hold_d;
            addr_q    <= addr_d;
            wd_q      <= wd_d;
            op_q      <= op_d;
            wr_q      <= wr_d;
        end
    end

    always_comb begin
        mis   = (memopM[2] && aluoutM[1:0] != 2'b00) ||
                (!memopM[2] && memopM[1] && aluoutM[0]);
        adelM = memenM & ~memwriteM & mis;
        adesM = memenM & memwriteM & mis;
        // rst gates start so outputs read idle during an asynchronous reset
        start = (state_q == S_IDLE) & memenM & ~flushM & ~mis & ~rst;

        // Once a transaction is in flight its fields come from the captured copy
        use_q    = (state_q != S_IDLE);
        req_addr = use_q ? addr_q : aluoutM;
        req_wd   = use_q ? wd_q   : writedataM;
        req_op   = use_q ? op_q   : memopM;
        req_wr   = use_q ? wr_q   : memwriteM;

        bus.data_addr = req_addr;
        bus.data_wr   = req_wr;
        if (req_op[2]) begin
            bus.data_size  = 2'd2;
            bus.data_wdata = req_wd;
            bus.data_wstrb = 4'b1111;
        end else if (req_op[1]) begin
            bus.data_size  = 2'd1;
            bus.data_wdata = {2{req_wd[15:0]}};
            bus.data_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
        end else begin
            bus.data_size  = 2'd0;
            bus.data_wdata = {4{req_wd[7:0]}};
            bus.data_wstrb = 4'b0001 << req_addr[1:0];
        end
        if (!req_wr)
            bus.data_wstrb = 4'b0000;

        load_data = wr_q ? 32'h0 : fmt_load(op_q, addr_q[1:0], bus.data_rdata);
    end

    always_comb begin
        state_d      = state_q;
        discard_d    = discard_q;
        hold_d       = hold_q;
        addr_d       = addr_q;
        wd_d         = wd_q;
        op_d         = op_q;
        wr_d         = wr_q;
        bus.data_req = 1'b0;
        stallM       = 1'b0;
        readdataM    = 32'h0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bus.data_req = 1'b1;
                    stallM       = 1'b1;
                    discard_d    = 1'b0;
                    addr_d       = aluoutM;
                    wd_d         = writedataM;
                    op_d         = memopM;
                    wr_d         = memwriteM;
                    state_d      = bus.data_addr_ok ? S_WAIT : S_REQ;
                end
            end
            S_REQ: begin
                bus.data_req = 1'b1;
                stallM       = 1'b1;
                if (flushM)
                    discard_d = 1'b1;
                if (bus.data_addr_ok)
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                stallM = ~bus.data_data_ok | discard_q;
                if (flushM)
                    discard_d = 1'b1;
                if (bus.data_data_ok) begin
                    discard_d = 1'b0;
                    if (discard_q) begin
                        state_d = S_IDLE;
                    end else begin
                        readdataM = load_data;
                        hold_d    = load_data;
                        state_d   = (advanceM || flushM) ? S_IDLE : S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                readdataM = hold_q;
                if (advanceM || flushM)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access: loads, stores, misalignment,
// delayed handshakes, flush discard, HOLD and asynchronous reset.
module tb_mem_access;
    logic        clk;
    logic        rst;
    logic        memenM, memwriteM, flushM, advanceM;
    logic [2:0]  memopM;
    logic [31:0] aluoutM, writedataM;
    logic [31:0] readdataM;
    logic        stallM, adelM, adesM;
    int          total, bad;

    mem_access_if bus ();

    mem_access dut (
        .clk        (clk),
        .rst        (rst),
        .memenM     (memenM),
        .memwriteM  (memwriteM),
        .memopM     (memopM),
        .aluoutM    (aluoutM),
        .writedataM (writedataM),
        .flushM     (flushM),
        .advanceM   (advanceM),
        .readdataM  (readdataM),
        .stallM     (stallM),
        .adelM      (adelM),
        .adesM      (adesM),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic quiet();
        memenM = 0; memwriteM = 0; memopM = 3'b000; aluoutM = 0; writedataM = 0;
        flushM = 0; advanceM = 0;
        bus.data_addr_ok = 0; bus.data_data_ok = 0; bus.data_rdata = 0;
    endtask

    task automatic set_m(input logic wr, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] wd);
        memenM = 1; memwriteM = wr; memopM = op; aluoutM = a; writedataM = wd;
    endtask

    task automatic test_reset();
        rst = 1; quiet();
        @(negedge clk);
        memenM = 1; memopM = 3'b100; aluoutM = 32'h100; bus.data_addr_ok = 1;
        #1;
        total++; if (bus.data_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", bus.data_req); end
        total++; if (stallM !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stallM); end
        total++; if (readdataM !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", readdataM); end
        @(negedge clk); quiet(); rst = 0;
        $display("txn reset done");
    endtask

    task automatic test_loads();
        logic [2:0]  ops  [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b001, 3'b100};
        logic [31:0] adrs [6] = '{32'h1003, 32'h1003, 32'h1002, 32'h1002, 32'h1000, 32'h1000};
        logic [31:0] exps [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF,
                                  32'h00000034, 32'h80FF1234};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_m(0, ops[i], adrs[i], 32'h0); bus.data_addr_ok = 1;
            #1;
            total++; if (bus.data_req !== 1'b1 || stallM !== 1'b1 || bus.data_wstrb !== 4'b0000 || adelM !== 1'b0)
                begin bad++; $display("FAIL load_issue[%0d] got req=%b stall=%b strb=%b adel=%b exp 1 1 0000 0", i, bus.data_req, stallM, bus.data_wstrb, adelM); end
            @(negedge clk);
            bus.data_addr_ok = 0; bus.data_data_ok = 1; bus.data_rdata = 32'h80FF1234; advanceM = 1;
            #1;
            total++; if (readdataM !== exps[i] || stallM !== 1'b0)
                begin bad++; $display("FAIL load_data[%0d] got=%h stall=%b exp=%h stall=0", i, readdataM, stallM, exps[i]); end
            $display("txn load op=%b addr=%h data=%h", ops[i], adrs[i], readdataM);
            @(negedge clk); quiet();
        end
    endtask

    task automatic test_stores();
        logic [2:0]  ops  [4] = '{3'b010, 3'b000, 3'b100, 3'b011};
        logic [31:0] adrs [4] = '{32'h2002, 32'h2001, 32'h2004, 32'h2000};
        logic [31:0] wds  [4] = '{32'h1234ABCD, 32'h000000A5, 32'h11223344, 32'h1234ABCD};
        logic [31:0] ewd  [4] = '{32'hABCDABCD, 32'hA5A5A5A5, 32'h11223344, 32'hABCDABCD};
        logic [3:0]  estb [4] = '{4'b1100, 4'b0010, 4'b1111, 4'b0011};
        logic [1:0]  esz  [4] = '{2'd1, 2'd0, 2'd2, 2'd1};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_m(1, ops[i], adrs[i], wds[i]); bus.data_addr_ok = 1;
            #1;
            total++; if (bus.data_req !== 1'b1 || bus.data_wr !== 1'b1 || bus.data_addr !== adrs[i])
                begin bad++; $display("FAIL store_req[%0d] got req=%b wr=%b addr=%h exp 1 1 %h", i, bus.data_req, bus.data_wr, bus.data_addr, adrs[i]); end
            total++; if (bus.data_wdata !== ewd[i] || bus.data_wstrb !== estb[i] || bus.data_size !== esz[i])
                begin bad++; $display("FAIL store_fmt[%0d] got wdata=%h strb=%b size=%0d exp %h %b %0d", i, bus.data_wdata, bus.data_wstrb, bus.data_size, ewd[i], estb[i], esz[i]); end
            @(negedge clk);
            bus.data_addr_ok = 0; bus.data_data_ok = 1; bus.data_rdata = 32'h5555AAAA; advanceM = 1;
            #1;
            total++; if (readdataM !== 32'h0 || stallM !== 1'b0)
                begin bad++; $display("FAIL store_done[%0d] got rdata=%h stall=%b exp 0 0", i, readdataM, stallM); end
            $display("txn store addr=%h wdata=%h strb=%b", adrs[i], ewd[i], estb[i]);
            @(negedge clk); quiet();
        end
    endtask

    task automatic test_misaligned();
        logic        wrs  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [2:0]  ops  [6] = '{3'b100, 3'b100, 3'b010, 3'b011, 3'b100, 3'b010};
        logic [31:0] adrs [6] = '{32'h3001, 32'h3002, 32'h3001, 32'h3003, 32'h3002, 32'h3001};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_m(wrs[i], ops[i], adrs[i], 32'hFFFFFFFF); bus.data_addr_ok = 1;
            #1;
            total++; if (adelM !== !wrs[i] || adesM !== wrs[i] || bus.data_req !== 1'b0 || stallM !== 1'b0)
                begin bad++; $display("FAIL misalign[%0d] got adel=%b ades=%b req=%b stall=%b exp %b %b 0 0", i, adelM, adesM, bus.data_req, stallM, !wrs[i], wrs[i]); end
            $display("txn misaligned wr=%b addr=%h", wrs[i], adrs[i]);
        end
        @(negedge clk); quiet();
    endtask

    task automatic test_delayed();
        int nstall = 0, nreq = 0;
        logic addr_bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            set_m(0, 3'b100, 32'h4000, 32'h0);
            bus.data_addr_ok = (c == 3); bus.data_data_ok = (c == 5);
            bus.data_rdata = (c == 5) ? 32'hDEADBEEF : 32'h0; advanceM = (c == 5);
            #1;
            if (stallM) nstall++;
            if (bus.data_req) begin nreq++; if (bus.data_addr !== 32'h4000) addr_bad = 1; end
            if (c == 5) begin
                total++; if (readdataM !== 32'hDEADBEEF) begin bad++; $display("FAIL delayed_data got=%h exp=deadbeef", readdataM); end
            end
        end
        @(negedge clk); quiet();
        total++; if (nstall !== 5) begin bad++; $display("FAIL delayed_stall_cycles got=%0d exp=5", nstall); end
        total++; if (nreq !== 4) begin bad++; $display("FAIL delayed_req_cycles got=%0d exp=4", nreq); end
        total++; if (addr_bad !== 1'b0) begin bad++; $display("FAIL delayed_addr_stable got=%b exp=0", addr_bad); end
        $display("txn delayed lw stall=%0d req=%0d", nstall, nreq);
    endtask

    task automatic test_flush_wait();
        @(negedge clk); set_m(0, 3'b100, 32'h5000, 32'h0); bus.data_addr_ok = 1;
        @(negedge clk); bus.data_addr_ok = 0; flushM = 1;
        #1;
        total++; if (stallM !== 1'b1 || bus.data_req !== 1'b0) begin bad++; $display("FAIL flush_c1 got stall=%b req=%b exp 1 0", stallM, bus.data_req); end
        @(negedge clk); flushM = 0; set_m(0, 3'b100, 32'h6004, 32'h0);
        #1;
        total++; if (stallM !== 1'b1 || bus.data_req !== 1'b0) begin bad++; $display("FAIL flush_c2 got stall=%b req=%b exp 1 0", stallM, bus.data_req); end
        @(negedge clk); bus.data_data_ok = 1; bus.data_rdata = 32'h11111111;
        #1;
        total++; if (readdataM !== 32'h0 || stallM !== 1'b1 || bus.data_req !== 1'b0)
            begin bad++; $display("FAIL flush_done got rdata=%h stall=%b req=%b exp 0 1 0", readdataM, stallM, bus.data_req); end
        @(negedge clk); bus.data_data_ok = 0; bus.data_rdata = 0; bus.data_addr_ok = 1;
        #1;
        total++; if (bus.data_req !== 1'b1 || bus.data_addr !== 32'h6004) begin bad++; $display("FAIL flush_next_req got req=%b addr=%h exp 1 6004", bus.data_req, bus.data_addr); end
        @(negedge clk); bus.data_addr_ok = 0; bus.data_data_ok = 1; bus.data_rdata = 32'h22223333; advanceM = 1;
        #1;
        total++; if (readdataM !== 32'h22223333 || stallM !== 1'b0) begin bad++; $display("FAIL flush_next_data got=%h stall=%b exp 22223333 0", readdataM, stallM); end
        $display("txn flush-in-wait then lw data=%h", readdataM);
        @(negedge clk); quiet();
    endtask

    task automatic test_hold();
        int nreq = 0;
        @(negedge clk); set_m(0, 3'b100, 32'h7000, 32'h0); bus.data_addr_ok = 1;
        #1; if (bus.data_req) nreq++;
        @(negedge clk); bus.data_addr_ok = 0; bus.data_data_ok = 1; bus.data_rdata = 32'hCAFEF00D;
        #1; if (bus.data_req) nreq++;
        total++; if (readdataM !== 32'hCAFEF00D || stallM !== 1'b0) begin bad++; $display("FAIL hold_done got=%h stall=%b exp cafef00d 0", readdataM, stallM); end
        @(negedge clk); bus.data_data_ok = 0; bus.data_rdata = 32'h0; bus.data_addr_ok = 1;
        #1; if (bus.data_req) nreq++;
        total++; if (readdataM !== 32'hCAFEF00D || stallM !== 1'b0) begin bad++; $display("FAIL hold_c2 got=%h stall=%b exp cafef00d 0", readdataM, stallM); end
        @(negedge clk); advanceM = 1;
        #1; if (bus.data_req) nreq++;
        total++; if (readdataM !== 32'hCAFEF00D) begin bad++; $display("FAIL hold_c3 got=%h exp cafef00d", readdataM); end
        total++; if (nreq !== 1) begin bad++; $display("FAIL hold_req_count got=%0d exp=1", nreq); end
        @(negedge clk); quiet();
        #1;
        total++; if (readdataM !== 32'h0) begin bad++; $display("FAIL hold_exit got=%h exp=0", readdataM); end
        $display("txn hold lw reqs=%0d", nreq);
    endtask

    task automatic test_reset_wait();
        @(negedge clk); set_m(0, 3'b100, 32'h8000, 32'h0); bus.data_addr_ok = 1;
        @(negedge clk); bus.data_addr_ok = 0;
        #1; rst = 1; #1;
        total++; if (bus.data_req !== 1'b0 || stallM !== 1'b0 || readdataM !== 32'h0)
            begin bad++; $display("FAIL rst_wait got req=%b stall=%b rdata=%h exp 0 0 0", bus.data_req, stallM, readdataM); end
        @(negedge clk); rst = 0; memenM = 0; bus.data_data_ok = 1; bus.data_rdata = 32'h12345678;
        #1;
        total++; if (readdataM !== 32'h0 || stallM !== 1'b0) begin bad++; $display("FAIL rst_stray got rdata=%h stall=%b exp 0 0", readdataM, stallM); end
        @(negedge clk); bus.data_data_ok = 0; set_m(0, 3'b100, 32'h8004, 32'h0); bus.data_addr_ok = 1;
        #1;
        total++; if (bus.data_req !== 1'b1 || bus.data_addr !== 32'h8004) begin bad++; $display("FAIL rst_restart got req=%b addr=%h exp 1 8004", bus.data_req, bus.data_addr); end
        @(negedge clk); bus.data_addr_ok = 0; bus.data_data_ok = 1; bus.data_rdata = 32'h0BADF00D; advanceM = 1;
        #1;
        total++; if (readdataM !== 32'h0BADF00D) begin bad++; $display("FAIL rst_restart_data got=%h exp 0badf00d", readdataM); end
        $display("txn reset-in-wait and restart");
        @(negedge clk); quiet();
    endtask

    initial begin
        total = 0; bad = 0;
        test_reset();
        test_loads();
        test_stores();
        test_misaligned();
        test_delayed();
        test_flush_wait();
        test_hold();
        test_reset_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
